// File: rtl/ux607_tl_d_coalescer.sv
`default_nettype none
// ============================================================================
//  Module   : ux607_tl_d_coalescer
//  Brief    : TileLink D-channel response coalescer. It absorbs replayed
//             responses, merges their error status, and forwards the final
//             beat through a one-entry registered output slot.
//  Config   : UX607_TL_D_COALESCER_ERR_ACC_EN enables error accumulation
//             across absorbed beats.
//  Revision : 1.0  initial release
// ============================================================================
module ux607_tl_d_coalescer #(
  parameter int DW = 32,
  parameter int SW = 2,
  parameter int CW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          io_drop,
  output logic          io_busy,
  output logic [CW-1:0] io_absorbed,
  output logic          io_enq_ready,
  input  logic          io_enq_valid,
  input  logic [2:0]    io_enq_bits_opcode,
  input  logic [1:0]    io_enq_bits_param,
  input  logic [2:0]    io_enq_bits_size,
  input  logic [SW-1:0] io_enq_bits_source,
  input  logic          io_enq_bits_sink,
  input  logic [DW-1:0] io_enq_bits_data,
  input  logic          io_enq_bits_error,
  input  logic          io_deq_ready,
  output logic          io_deq_valid,
  output logic [2:0]    io_deq_bits_opcode,
  output logic [1:0]    io_deq_bits_param,
  output logic [2:0]    io_deq_bits_size,
  output logic [SW-1:0] io_deq_bits_source,
  output logic          io_deq_bits_sink,
  output logic [DW-1:0] io_deq_bits_data,
  output logic          io_deq_bits_error
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic          out_valid_q, out_valid_d;
  logic [2:0]    opcode_q, opcode_d;
  logic [1:0]    param_q, param_d;
  logic [2:0]    size_q, size_d;
  logic [SW-1:0] source_q, source_d;
  logic          sink_q, sink_d;
  logic [DW-1:0] data_q, data_d;
  logic          error_q, error_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic accept;
  logic fwd;
  logic absorb;
  logic drain;
  logic fwd_err;

  // Absorbed beats never need the out slot, so they are never back-pressured.
  assign io_enq_ready = io_drop | ~out_valid_q | io_deq_ready;
  assign accept       = io_enq_valid & io_enq_ready;
  assign fwd          = accept & ~io_drop;
  assign absorb       = accept & io_drop;
  assign drain        = out_valid_q & io_deq_ready;

`ifdef UX607_TL_D_COALESCER_ERR_ACC_EN
  logic err_acc_q, err_acc_d;

  assign fwd_err = io_enq_bits_error | err_acc_q;

  always_comb begin
    err_acc_d = err_acc_q;
    if (fwd) begin
      err_acc_d = 1'b0;
    end else if (absorb) begin
      err_acc_d = err_acc_q | io_enq_bits_error;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_acc_q <= 1'b0;
    end else begin
      err_acc_q <= err_acc_d;
    end
  end
`else
  assign fwd_err = io_enq_bits_error;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    param_d     = param_q;
    size_d      = size_q;
    source_d    = source_q;
    sink_d      = sink_q;
    data_d      = data_q;
    error_d     = error_q;
    cnt_d       = cnt_q;
    // A forward wins over a simultaneous drain: the slot reloads and stays valid.
    if (fwd) begin
      out_valid_d = 1'b1;
      opcode_d    = io_enq_bits_opcode;
      param_d     = io_enq_bits_param;
      size_d      = io_enq_bits_size;
      source_d    = io_enq_bits_source;
      sink_d      = io_enq_bits_sink;
      data_d      = io_enq_bits_data;
      error_d     = fwd_err;
      cnt_d       = '0;
    end else begin
      if (drain) begin
        out_valid_d = 1'b0;
      end
      if (absorb && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      param_q     <= '0;
      size_q      <= '0;
      source_q    <= '0;
      sink_q      <= 1'b0;
      data_q      <= '0;
      error_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      param_q     <= param_d;
      size_q      <= size_d;
      source_q    <= source_d;
      sink_q      <= sink_d;
      data_q      <= data_d;
      error_q     <= error_d;
      cnt_q       <= cnt_d;
    end
  end

  assign io_busy            = (cnt_q != '0);
  assign io_absorbed        = cnt_q;
  assign io_deq_valid       = out_valid_q;
  assign io_deq_bits_opcode = opcode_q;
  assign io_deq_bits_param  = param_q;
  assign io_deq_bits_size   = size_q;
  assign io_deq_bits_source = source_q;
  assign io_deq_bits_sink   = sink_q;
  assign io_deq_bits_data   = data_q;
  assign io_deq_bits_error  = error_q;

endmodule
`default_nettype wire

// File: tb/tb_ux607_tl_d_coalescer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ux607_tl_d_coalescer
//  Brief    : Self-checking bench for ux607_tl_d_coalescer; directed scenarios
//             plus randomized traffic against a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ux607_tl_d_coalescer;

  localparam int DW      = 32;
  localparam int SW      = 2;
  localparam int CW      = 4;
  localparam int SAT_MAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          io_drop = 1'b0;
  logic          io_busy;
  logic [CW-1:0] io_absorbed;
  logic          io_enq_ready;
  logic          io_enq_valid = 1'b0;
  logic [2:0]    io_enq_bits_opcode = '0;
  logic [1:0]    io_enq_bits_param = '0;
  logic [2:0]    io_enq_bits_size = '0;
  logic [SW-1:0] io_enq_bits_source = '0;
  logic          io_enq_bits_sink = 1'b0;
  logic [DW-1:0] io_enq_bits_data = '0;
  logic          io_enq_bits_error = 1'b0;
  logic          io_deq_ready = 1'b0;
  logic          io_deq_valid;
  logic [2:0]    io_deq_bits_opcode;
  logic [1:0]    io_deq_bits_param;
  logic [2:0]    io_deq_bits_size;
  logic [SW-1:0] io_deq_bits_source;
  logic          io_deq_bits_sink;
  logic [DW-1:0] io_deq_bits_data;
  logic          io_deq_bits_error;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ux607_tl_d_coalescer #(.DW(DW), .SW(SW), .CW(CW)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_drop            (io_drop),
    .io_busy            (io_busy),
    .io_absorbed        (io_absorbed),
    .io_enq_ready       (io_enq_ready),
    .io_enq_valid       (io_enq_valid),
    .io_enq_bits_opcode (io_enq_bits_opcode),
    .io_enq_bits_param  (io_enq_bits_param),
    .io_enq_bits_size   (io_enq_bits_size),
    .io_enq_bits_source (io_enq_bits_source),
    .io_enq_bits_sink   (io_enq_bits_sink),
    .io_enq_bits_data   (io_enq_bits_data),
    .io_enq_bits_error  (io_enq_bits_error),
    .io_deq_ready       (io_deq_ready),
    .io_deq_valid       (io_deq_valid),
    .io_deq_bits_opcode (io_deq_bits_opcode),
    .io_deq_bits_param  (io_deq_bits_param),
    .io_deq_bits_size   (io_deq_bits_size),
    .io_deq_bits_source (io_deq_bits_source),
    .io_deq_bits_sink   (io_deq_bits_sink),
    .io_deq_bits_data   (io_deq_bits_data),
    .io_deq_bits_error  (io_deq_bits_error)
  );

  // Transaction-level model: pending forwarded responses, absorbed count, merged error.
  typedef struct {
    logic [2:0]    opcode;
    logic [1:0]    param;
    logic [2:0]    size;
    logic [SW-1:0] source;
    logic          sink;
    logic [DW-1:0] data;
    logic          error;
  } resp_t;

  resp_t m_q[$];
  int    m_cnt = 0;
  bit    m_err = 1'b0;

`ifdef UX607_TL_D_COALESCER_ERR_ACC_EN
  localparam bit MERGE_EN = 1'b1;
`else
  localparam bit MERGE_EN = 1'b0;
`endif

  function automatic bit model_ready();
    return io_drop || (m_q.size() == 0) || io_deq_ready;
  endfunction

  // Advance one clock and apply the same beat to the model; returns at the next negedge.
  task automatic tick();
    bit    acc;
    resp_t r;
    acc = io_enq_valid && model_ready();
    @(posedge clock);
    if (reset) begin
      m_q.delete();
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      if ((m_q.size() != 0) && io_deq_ready) void'(m_q.pop_front());
      if (acc && io_drop) begin
        if (m_cnt < SAT_MAX) m_cnt++;
        m_err = m_err | io_enq_bits_error;
      end else if (acc) begin
        r.opcode = io_enq_bits_opcode;
        r.param  = io_enq_bits_param;
        r.size   = io_enq_bits_size;
        r.source = io_enq_bits_source;
        r.sink   = io_enq_bits_sink;
        r.data   = io_enq_bits_data;
        r.error  = io_enq_bits_error | (MERGE_EN & m_err);
        m_q.push_back(r);
        m_cnt = 0;
        m_err = 1'b0;
      end
    end
    @(negedge clock);
  endtask

  task automatic set_beat(input bit valid, input bit drop, input logic [2:0] op,
                          input logic [SW-1:0] src, input logic [DW-1:0] data,
                          input bit err);
    io_enq_valid       = valid;
    io_drop            = drop;
    io_enq_bits_opcode = op;
    io_enq_bits_param  = '0;
    io_enq_bits_size   = 3'd2;
    io_enq_bits_source = src;
    io_enq_bits_sink   = 1'b0;
    io_enq_bits_data   = data;
    io_enq_bits_error  = err;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_beat(0, 0, 3'd0, '0, '0, 0);
    io_deq_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (io_deq_valid !== 1'b0) begin
      failures++; $display("FAIL reset_deq_valid got=%0b exp=0", io_deq_valid);
    end
    checks++;
    if (io_enq_ready !== 1'b1) begin
      failures++; $display("FAIL reset_enq_ready got=%0b exp=1", io_enq_ready);
    end
    checks++;
    if (io_absorbed !== '0 || io_busy !== 1'b0) begin
      failures++; $display("FAIL reset_absorbed got=%0d busy=%0b exp=0/0", io_absorbed, io_busy);
    end
    checks++;
    if (io_deq_bits_data !== '0 || io_deq_bits_opcode !== '0 || io_deq_bits_error !== 1'b0) begin
      failures++; $display("FAIL reset_bits got data=%h op=%0d err=%0b exp=0", io_deq_bits_data, io_deq_bits_opcode, io_deq_bits_error);
    end
  endtask

  task automatic test_single_forward();
    io_deq_ready = 1'b1;
    set_beat(1, 0, 3'd1, 2'd2, 32'hDEADBEEF, 0);
    tick();
    set_beat(0, 0, 3'd0, '0, '0, 0);
    #1;
    checks++;
    if (io_deq_valid !== 1'b1 || io_deq_bits_data !== 32'hDEADBEEF || io_deq_bits_opcode !== 3'd1 ||
        io_deq_bits_source !== 2'd2 || io_deq_bits_error !== 1'b0) begin
      failures++;
      $display("FAIL single_fwd got v=%0b data=%h op=%0d src=%0d err=%0b exp v=1 data=deadbeef op=1 src=2 err=0",
               io_deq_valid, io_deq_bits_data, io_deq_bits_opcode, io_deq_bits_source, io_deq_bits_error);
    end
    tick();
    checks++;
    if (io_deq_valid !== 1'b0) begin
      failures++; $display("FAIL single_drain got v=%0b exp=0", io_deq_valid);
    end
  endtask

  task automatic test_merge_error();
    io_deq_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_beat(1, 1, 3'd1, 2'd1, 32'h100 + i, (i == 1));
      tick();
      checks++;
      if (io_absorbed !== CW'(i + 1) || io_busy !== 1'b1) begin
        failures++; $display("FAIL merge_absorbed[%0d] got=%0d busy=%0b exp=%0d/1", i, io_absorbed, io_busy, i + 1);
      end
    end
    set_beat(1, 0, 3'd1, 2'd1, 32'h200, 0);
    tick();
    set_beat(0, 0, 3'd0, '0, '0, 0);
    #1;
    checks++;
    if (io_deq_valid !== 1'b1 || io_deq_bits_data !== 32'h200 || io_deq_bits_error !== MERGE_EN) begin
      failures++; $display("FAIL merge_fwd got v=%0b data=%h err=%0b exp v=1 data=200 err=%0b",
                           io_deq_valid, io_deq_bits_data, io_deq_bits_error, MERGE_EN);
    end
    checks++;
    if (io_absorbed !== '0 || io_busy !== 1'b0) begin
      failures++; $display("FAIL merge_clear got=%0d busy=%0b exp=0/0", io_absorbed, io_busy);
    end
    tick();
  endtask

  task automatic test_backpressure();
    io_deq_ready = 1'b0;
    set_beat(1, 0, 3'd4, 2'd3, 32'hAAAA_0001, 0);
    tick();
    set_beat(1, 0, 3'd5, 2'd0, 32'hBBBB_0002, 0);
    #1;
    checks++;
    if (io_enq_ready !== 1'b0) begin
      failures++; $display("FAIL bp_fwd_stall got ready=%0b exp=0", io_enq_ready);
    end
    tick();
    checks++;
    if (io_deq_valid !== 1'b1 || io_deq_bits_data !== 32'hAAAA_0001) begin
      failures++; $display("FAIL bp_hold got v=%0b data=%h exp v=1 data=aaaa0001", io_deq_valid, io_deq_bits_data);
    end
    io_drop = 1'b1;
    #1;
    checks++;
    if (io_enq_ready !== 1'b1) begin
      failures++; $display("FAIL bp_drop_ready got=%0b exp=1", io_enq_ready);
    end
    tick();
    checks++;
    if (io_absorbed !== CW'(1) || io_deq_bits_data !== 32'hAAAA_0001) begin
      failures++; $display("FAIL bp_drop_absorb got cnt=%0d data=%h exp cnt=1 data=aaaa0001", io_absorbed, io_deq_bits_data);
    end
    io_drop = 1'b0;
    io_deq_ready = 1'b1;
    #1;
    checks++;
    if (io_enq_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release_ready got=%0b exp=1", io_enq_ready);
    end
    tick();
    set_beat(0, 0, 3'd0, '0, '0, 0);
    #1;
    checks++;
    if (io_deq_valid !== 1'b1 || io_deq_bits_data !== 32'hBBBB_0002 || io_absorbed !== '0) begin
      failures++; $display("FAIL bp_release got v=%0b data=%h cnt=%0d exp v=1 data=bbbb0002 cnt=0",
                           io_deq_valid, io_deq_bits_data, io_absorbed);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    io_deq_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_beat(1, 0, 3'd1, 2'd0, DW'(i), 0);
      tick();
      checks++;
      if (io_deq_valid !== 1'b1 || io_deq_bits_data !== DW'(i)) begin
        failures++; $display("FAIL stream[%0d] got v=%0b data=%0d exp v=1 data=%0d", i, io_deq_valid, io_deq_bits_data, i);
      end
    end
    set_beat(0, 0, 3'd0, '0, '0, 0);
    tick();
    checks++;
    if (io_deq_valid !== 1'b0) begin
      failures++; $display("FAIL stream_end got v=%0b exp=0", io_deq_valid);
    end
  endtask

  task automatic test_saturation_reset();
    io_deq_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_beat(1, 1, 3'd1, 2'd0, DW'(i), 1);
      tick();
    end
    checks++;
    if (io_absorbed !== CW'(SAT_MAX) || io_busy !== 1'b1) begin
      failures++; $display("FAIL sat_count got=%0d busy=%0b exp=%0d/1", io_absorbed, io_busy, SAT_MAX);
    end
    set_beat(0, 0, 3'd0, '0, '0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (io_absorbed !== '0 || io_busy !== 1'b0) begin
      failures++; $display("FAIL sat_reset got=%0d busy=%0b exp=0/0", io_absorbed, io_busy);
    end
    set_beat(1, 0, 3'd1, 2'd1, 32'h5A5A, 0);
    tick();
    set_beat(0, 0, 3'd0, '0, '0, 0);
    #1;
    checks++;
    if (io_deq_valid !== 1'b1 || io_deq_bits_error !== 1'b0) begin
      failures++; $display("FAIL sat_post_reset got v=%0b err=%0b exp v=1 err=0", io_deq_valid, io_deq_bits_error);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      io_enq_valid       = ($urandom_range(0, 3) != 0);
      io_drop            = ($urandom_range(0, 2) == 0);
      io_enq_bits_opcode = 3'($urandom);
      io_enq_bits_param  = 2'($urandom);
      io_enq_bits_size   = 3'($urandom);
      io_enq_bits_source = SW'($urandom);
      io_enq_bits_sink   = 1'($urandom);
      io_enq_bits_data   = DW'($urandom);
      io_enq_bits_error  = ($urandom_range(0, 5) == 0);
      io_deq_ready       = ($urandom_range(0, 2) != 0);
      #1;
      checks++;
      if (io_enq_ready !== model_ready()) begin
        failures++; $display("FAIL rnd_ready[%0d] got=%0b exp=%0b", n, io_enq_ready, model_ready());
      end
      tick();
      checks++;
      if (io_deq_valid !== (m_q.size() != 0) || io_absorbed !== CW'(m_cnt) || io_busy !== (m_cnt != 0)) begin
        failures++; $display("FAIL rnd_state[%0d] got v=%0b cnt=%0d busy=%0b exp v=%0b cnt=%0d",
                             n, io_deq_valid, io_absorbed, io_busy, (m_q.size() != 0), m_cnt);
      end else if (m_q.size() != 0) begin
        checks++;
        if (io_deq_bits_opcode !== m_q[0].opcode || io_deq_bits_param !== m_q[0].param ||
            io_deq_bits_size !== m_q[0].size || io_deq_bits_source !== m_q[0].source ||
            io_deq_bits_sink !== m_q[0].sink || io_deq_bits_data !== m_q[0].data ||
            io_deq_bits_error !== m_q[0].error) begin
          failures++; $display("FAIL rnd_bits[%0d] got data=%h err=%0b op=%0d exp data=%h err=%0b op=%0d",
                               n, io_deq_bits_data, io_deq_bits_error, io_deq_bits_opcode,
                               m_q[0].data, m_q[0].error, m_q[0].opcode);
        end
      end
    end
    set_beat(0, 0, 3'd0, '0, '0, 0);
    io_deq_ready = 1'b1;
    tick();
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_single_forward();
    test_merge_error();
    test_backpressure();
    test_back_to_back();
    test_saturation_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
